tbus_mem_responder: RTL and testbench

- Responder (target) end of the trinity bus (tbus) channel, the side that arbiter-facing initiators such as the load/store units issue requests into.
- Accepts one read or write request at a time over the index valid/ready handshake.
- Services the request against an internal 64-bit-word memory array after a fixed, parameterised latency.
- Returns the result with a single-cycle operation_done pulse; used as the memory-side model behind the arbiter and as a simple backing store for memblock bring-up.

---
 rtl/tbus_pkg.sv | 24 ++
 rtl/tbus_rsp_mem.sv | 31 +++
 rtl/tbus_mem_responder.sv | 138 +++++++++++++
 tb/tb_tbus_mem_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbus_pkg.sv
// Shared trinity-bus definitions: operation encodings, data width, responder
// FSM states and the backpressure LFSR step used by tbus_mem_responder.
package tbus_pkg;

    localparam int TBUS_DATA_W   = 64;
    localparam int TBUS_OPTYPE_W = 2;

    localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'b00;
    localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'b01;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } tbus_rsp_state_e;

    localparam logic [7:0] TBUS_LFSR_SEED = 8'hA5;

    // Fibonacci LFSR, taps 8,6,5,4, shifting towards the MSB.
    function automatic logic [7:0] tbus_lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/tbus_rsp_mem.sv
// DEPTH x 64-bit backing array for the tbus responder: asynchronous read port
// and a bit-masked read-modify-write port sharing one word address.
module tbus_rsp_mem
    import tbus_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                       clock,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [TBUS_DATA_W-1:0]     wr_data,
    input  logic [TBUS_DATA_W-1:0]     wr_mask,
    output logic [TBUS_DATA_W-1:0]     rd_data
);

    logic [TBUS_DATA_W-1:0] mem_q [DEPTH];
    logic [TBUS_DATA_W-1:0] merged_d;

    assign rd_data = mem_q[addr];

    always_comb begin
        merged_d = (mem_q[addr] & ~wr_mask) | (wr_data & wr_mask);
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[addr] <= merged_d;
        end
    end

endmodule

// File: rtl/tbus_mem_responder.sv
// Memory-side responder of the trinity bus: one request at a time, fixed LATENCY.
// Optional `TBUS_RSP_BACKPRESSURE_EN adds LFSR-driven deassertion of index_ready.
module tbus_mem_responder
    import tbus_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int LATENCY  = 2,
    parameter int ADDR_LSB = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      tbus_index_valid,
    output logic                      tbus_index_ready,
    input  logic [TBUS_DATA_W-1:0]    tbus_index,
    input  logic [TBUS_OPTYPE_W-1:0]  tbus_operation_type,
    input  logic [TBUS_DATA_W-1:0]    tbus_write_data,
    input  logic [TBUS_DATA_W-1:0]    tbus_write_mask,
    output logic [TBUS_DATA_W-1:0]    tbus_read_data,
    output logic                      tbus_operation_done,
    input  logic                      flush
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int HI    = ADDR_LSB + IDX_W;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    tbus_rsp_state_e            state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [TBUS_DATA_W-1:0]     idx_q, idx_d;
    logic [TBUS_OPTYPE_W-1:0]   op_q, op_d;
    logic [TBUS_DATA_W-1:0]     wdata_q, wdata_d;
    logic [TBUS_DATA_W-1:0]     wmask_q, wmask_d;

    logic                       bp_stall;
    logic                       fire;
    logic                       in_range;
    logic                       mem_we;
    logic [TBUS_DATA_W-1:0]     mem_rdata;

`ifdef TBUS_RSP_BACKPRESSURE_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d   = tbus_lfsr_next(lfsr_q);
    assign bp_stall = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= TBUS_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign bp_stall = 1'b0;
`endif

    // Reset and flush both suppress handshake and completion combinationally,
    // so an aborted request can never produce a done pulse or a write commit.
    assign tbus_index_ready    = (state_q == RSP_IDLE) & ~flush & ~reset & ~bp_stall;
    assign tbus_operation_done = (state_q == RSP_RESP) & ~flush & ~reset;
    assign fire                = tbus_index_valid & tbus_index_ready;
    assign in_range            = ((idx_q >> HI) == '0);

    assign mem_we         = tbus_operation_done & (op_q == TBUS_WRITE) & in_range;
    assign tbus_read_data = (tbus_operation_done & (op_q == TBUS_READ) & in_range)
                            ? mem_rdata : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            RSP_IDLE: begin
                if (fire) begin
                    idx_d   = tbus_index;
                    op_d    = tbus_operation_type;
                    wdata_d = tbus_write_data;
                    wmask_d = tbus_write_mask;
                    if (LATENCY == 1) begin
                        state_d = RSP_RESP;
                    end else begin
                        state_d = RSP_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            RSP_WAIT: begin
                if (flush) begin
                    state_d = RSP_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RSP_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RSP_RESP: begin
                state_d = RSP_IDLE;
            end
            default: begin
                state_d = RSP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RSP_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    tbus_rsp_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (mem_we),
        .addr    (idx_q[ADDR_LSB +: IDX_W]),
        .wr_data (wdata_q),
        .wr_mask (wmask_q),
        .rd_data (mem_rdata)
    );

endmodule

// File: tb/tb_tbus_mem_responder.sv
// Self-checking bench for tbus_mem_responder: directed scenarios plus a random
// read/write stream checked against an array model; a second LATENCY=1 instance.
module tb_tbus_mem_responder;
    import tbus_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid, flush;
    logic [1:0]  optype;
    logic [63:0] index, wdata, wmask;
    logic        ready, done;
    logic [63:0] rdata;

    logic        v1, fl1;
    logic [1:0]  op1;
    logic [63:0] idx1, wd1, wm1;
    logic        ready1, done1;
    logic [63:0] rd1;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    tbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDR_LSB(3)) dut (
        .clock(clock), .reset(reset),
        .tbus_index_valid(valid), .tbus_index_ready(ready),
        .tbus_index(index), .tbus_operation_type(optype),
        .tbus_write_data(wdata), .tbus_write_mask(wmask),
        .tbus_read_data(rdata), .tbus_operation_done(done),
        .flush(flush)
    );

    tbus_mem_responder #(.DEPTH(16), .LATENCY(1), .ADDR_LSB(3)) dut1 (
        .clock(clock), .reset(reset),
        .tbus_index_valid(v1), .tbus_index_ready(ready1),
        .tbus_index(idx1), .tbus_operation_type(op1),
        .tbus_write_data(wd1), .tbus_write_mask(wm1),
        .tbus_read_data(rd1), .tbus_operation_done(done1),
        .flush(fl1)
    );

    // All tasks start and end 1 time unit after a rising edge; sampling is at +2.
    task automatic issue(input logic [1:0] op, input logic [63:0] idx, input logic [63:0] wd,
                         input logic [63:0] mk, output bit ok, output int fc);
        ok = 0; fc = -1;
        valid = 1'b1; optype = op; index = idx; wdata = wd; wmask = mk;
        for (int k = 0; k < 64 && !ok; k++) begin
            #1;
            if (ready === 1'b1) begin ok = 1; fc = cyc; end
            @(posedge clock); #1;
        end
        valid = 1'b0;
        optype = 2'($urandom); index = {$urandom, $urandom};
        wdata = {$urandom, $urandom}; wmask = {$urandom, $urandom};
    endtask

    task automatic wait_done(output bit seen, output int dc, output logic [63:0] d);
        seen = 0; dc = -1; d = 'x;
        for (int k = 0; k < 64 && !seen; k++) begin
            #1;
            if (done === 1'b1) begin seen = 1; dc = cyc; d = rdata; end
            @(posedge clock); #1;
        end
    endtask

    task automatic xact(input logic [1:0] op, input logic [63:0] idx, input logic [63:0] wd,
                        input logic [63:0] mk, output int lat, output logic [63:0] d,
                        output bit single);
        bit ok, seen;
        int fc, dc;
        lat = -1; d = 'x; single = 0;
        issue(op, idx, wd, mk, ok, fc);
        if (ok) begin
            wait_done(seen, dc, d);
            if (seen) begin
                lat = dc - fc;
                #1;
                single = (done === 1'b0);
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic xact1(input logic [1:0] op, input logic [63:0] idx, input logic [63:0] wd,
                         input logic [63:0] mk, output int lat, output logic [63:0] d);
        int fc, dc;
        fc = -1; dc = -1; d = 'x;
        v1 = 1'b1; op1 = op; idx1 = idx; wd1 = wd; wm1 = mk;
        for (int k = 0; k < 64 && fc < 0; k++) begin
            #1;
            if (ready1 === 1'b1) fc = cyc;
            @(posedge clock); #1;
        end
        v1 = 1'b0;
        for (int k = 0; k < 64 && dc < 0 && fc >= 0; k++) begin
            #1;
            if (done1 === 1'b1) begin dc = cyc; d = rd1; end
            @(posedge clock); #1;
        end
        lat = (fc >= 0 && dc >= 0) ? dc - fc : -1;
    endtask

    task automatic test_reset();
        valid = 0; flush = 0; optype = TBUS_READ; index = 0; wdata = 0; wmask = 0;
        v1 = 0; fl1 = 0; op1 = TBUS_READ; idx1 = 0; wd1 = 0; wm1 = 0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0", ready); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", done); end
        n_cmp++; if (rdata !== 64'h0) begin n_bad++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        n_cmp++; if (ready1 !== 1'b0) begin n_bad++; $display("FAIL rst_ready1: got %b expected 0", ready1); end
        reset = 1'b0;
        @(posedge clock); #2;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_idle_ready: got %b expected 1", ready); end
        @(posedge clock); #1;
    endtask

    task automatic test_write_read();
        int lat; logic [63:0] d; bit single;
        xact(TBUS_WRITE, 64'h40, 64'hDEAD_BEEF_0123_4567, '1, lat, d, single);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (d !== 64'h0) begin n_bad++; $display("FAIL wr_rdata: got %h expected 0", d); end
        n_cmp++; if (single !== 1'b1) begin n_bad++; $display("FAIL wr_done_width: got %b expected 1", single); end
        xact(TBUS_READ, 64'h40, 64'h0, 64'h0, lat, d, single);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (d !== 64'hDEAD_BEEF_0123_4567) begin n_bad++; $display("FAIL rd_data: got %h expected deadbeef01234567", d); end
    endtask

    task automatic test_masked_write();
        int lat; logic [63:0] d; bit single;
        xact(TBUS_WRITE, 64'h40, '1, 64'h0000_0000_FFFF_0000, lat, d, single);
        xact(TBUS_READ, 64'h40, 64'h0, 64'h0, lat, d, single);
        n_cmp++; if (d !== 64'hDEAD_BEEF_FFFF_4567) begin n_bad++; $display("FAIL masked_rd: got %h expected deadbeefffff4567", d); end
        xact(TBUS_READ, 64'h44, 64'h0, 64'h0, lat, d, single);
        n_cmp++; if (d !== 64'hDEAD_BEEF_FFFF_4567) begin n_bad++; $display("FAIL offset_rd: got %h expected deadbeefffff4567", d); end
    endtask

    task automatic test_flush();
        int lat, fc; logic [63:0] d; bit single, ok;
        xact(TBUS_WRITE, 64'h80, 64'h1111, '1, lat, d, single);
        // flush while the request waits
        issue(TBUS_WRITE, 64'h80, 64'h2222, '1, ok, fc);
        flush = 1'b1; #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_wait_done: got %b expected 0", done); end
        @(posedge clock); #1; flush = 1'b0; #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_no_done: got %b expected 0", done); end
`ifndef TBUS_RSP_BACKPRESSURE_EN
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready_back: got %b expected 1", ready); end
`endif
        @(posedge clock); #1;
        // flush during the response cycle
        issue(TBUS_WRITE, 64'h80, 64'h3333, '1, ok, fc);
        @(posedge clock); #1; flush = 1'b1; #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_resp_done: got %b expected 0", done); end
        @(posedge clock); #1; flush = 1'b0;
        @(posedge clock); #1;
        xact(TBUS_READ, 64'h80, 64'h0, 64'h0, lat, d, single);
        n_cmp++; if (d !== 64'h1111) begin n_bad++; $display("FAIL flush_no_commit: got %h expected 1111", d); end
    endtask

    task automatic test_back_to_back();
        int f1, f2, lat, ndone; logic [63:0] d; bit seen, single; int dc;
        f1 = -1; f2 = -1;
        valid = 1'b1; optype = TBUS_READ; index = 64'h40;
        for (int k = 0; k < 64 && f1 < 0; k++) begin
            #1; if (ready === 1'b1) f1 = cyc;
            @(posedge clock); #1;
        end
        for (int k = 1; k <= LAT; k++) begin
            #1;
            n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_ready: got %b expected 0 at +%0d", ready, k); end
            if (k == LAT) begin
                n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done1: got %b expected 1", done); end
                n_cmp++; if (rdata !== 64'hDEAD_BEEF_FFFF_4567) begin n_bad++; $display("FAIL b2b_data1: got %h expected deadbeefffff4567", rdata); end
            end
            @(posedge clock); #1;
        end
        for (int k = 0; k < 64 && f2 < 0; k++) begin
            #1; if (ready === 1'b1) f2 = cyc;
            @(posedge clock); #1;
        end
        valid = 1'b0;
`ifndef TBUS_RSP_BACKPRESSURE_EN
        n_cmp++; if (f2 !== f1 + LAT + 1) begin n_bad++; $display("FAIL b2b_second_fire: got %0d expected %0d", f2, f1 + LAT + 1); end
`endif
        wait_done(seen, dc, d);
        n_cmp++; if (dc - f2 !== LAT || f2 < 0) begin n_bad++; $display("FAIL b2b_latency2: got %0d expected %0d", dc - f2, LAT); end
        n_cmp++; if (d !== 64'hDEAD_BEEF_FFFF_4567) begin n_bad++; $display("FAIL b2b_data2: got %h expected deadbeefffff4567", d); end
        // flush in IDLE blocks acceptance
        valid = 1'b1; flush = 1'b1; optype = TBUS_WRITE; index = 64'h40; wdata = 0; wmask = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL idle_flush_ready: got %b expected 0", ready); end
            @(posedge clock); #1;
        end
        valid = 1'b0; flush = 1'b0;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            #1; if (done !== 1'b0) ndone++;
            @(posedge clock); #1;
        end
        n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL idle_flush_no_fire: got %0d dones expected 0", ndone); end
        // out-of-range and unknown operations
        xact(TBUS_READ, 64'(DEPTH) * 8, 64'h0, 64'h0, lat, d, single);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL oob_rd_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if (d !== 64'h0) begin n_bad++; $display("FAIL oob_rd_data: got %h expected 0", d); end
        xact(TBUS_WRITE, 64'(DEPTH + 8) * 8, 64'h0, '1, lat, d, single);
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL oob_wr_latency: got %0d expected %0d", lat, LAT); end
        xact(2'b10, 64'h40, 64'h0, 64'h0, lat, d, single);
        n_cmp++; if (d !== 64'h0 || lat !== LAT) begin n_bad++; $display("FAIL bad_op_rd: got %h/%0d expected 0/%0d", d, lat, LAT); end
        xact(2'b11, 64'h40, 64'h0, '1, lat, d, single);
        n_cmp++; if (d !== 64'h0 || lat !== LAT) begin n_bad++; $display("FAIL bad_op3_rd: got %h/%0d expected 0/%0d", d, lat, LAT); end
        xact(TBUS_READ, 64'h40, 64'h0, 64'h0, lat, d, single);
        n_cmp++; if (d !== 64'hDEAD_BEEF_FFFF_4567) begin n_bad++; $display("FAIL oob_wr_dropped: got %h expected deadbeefffff4567", d); end
    endtask

    task automatic test_reset_mid();
        int lat, fc; logic [63:0] d; bit single, ok;
        issue(TBUS_WRITE, 64'h40, 64'h0, '1, ok, fc);
        reset = 1'b1; #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done); end
        @(posedge clock); #1; reset = 1'b0; #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done: got %b expected 0", done); end
        @(posedge clock); #1;
        xact(TBUS_READ, 64'h40, 64'h0, 64'h0, lat, d, single);
        n_cmp++; if (d !== 64'hDEAD_BEEF_FFFF_4567) begin n_bad++; $display("FAIL midrst_no_commit: got %h expected deadbeefffff4567", d); end
    endtask

    task automatic test_latency1();
        int lat; logic [63:0] d;
        xact1(TBUS_WRITE, 64'h8, 64'h5A5A, '1, lat, d);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL lat1_wr: got %0d expected 1", lat); end
        xact1(TBUS_READ, 64'hC, 64'h0, 64'h0, lat, d);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL lat1_rd: got %0d expected 1", lat); end
        n_cmp++; if (d !== 64'h5A5A) begin n_bad++; $display("FAIL lat1_data: got %h expected 5a5a", d); end
    endtask

    task automatic test_random();
        logic [63:0] ref_mem [16];
        logic [63:0] d, dat, msk, exp_d, idx;
        logic [1:0]  op;
        int lat, w, r;
        bit single;
        for (int i = 0; i < 16; i++) begin
            dat = {$urandom, $urandom};
            xact(TBUS_WRITE, 64'(i) * 8, dat, '1, lat, d, single);
            ref_mem[i] = dat;
        end
        for (int n = 0; n < 100; n++) begin
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 15);
            dat = {$urandom, $urandom};
            msk = {$urandom, $urandom};
            idx = 64'(w) * 8 + 64'($urandom_range(0, 7));
            op = (r < 4) ? TBUS_READ : (r < 8) ? TBUS_WRITE : (r == 8) ? 2'($urandom_range(0, 1)) : 2'b10 + 2'($urandom_range(0, 1));
            if (r == 8) idx = 64'(DEPTH + w) * 8;
            exp_d = 64'h0;
            if (r < 4) exp_d = ref_mem[w];
            else if (r < 8) ref_mem[w] = (ref_mem[w] & ~msk) | (dat & msk);
            xact(op, idx, dat, msk, lat, d, single);
            n_cmp++; if (lat !== LAT || single !== 1'b1) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d/%b expected %0d/1", n, lat, single, LAT); end
            n_cmp++; if (d !== exp_d) begin n_bad++; $display("FAIL rnd_data[%0d]: op %0d idx %h got %h expected %h", n, op, idx, d, exp_d); end
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        end
    endtask

`ifdef TBUS_RSP_BACKPRESSURE_EN
    task automatic test_backpressure();
        logic [7:0] lf;
        logic exp_rdy;
        reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        lf = 8'hA5;
        for (int k = 0; k < 40; k++) begin
            #1;
            exp_rdy = (lf[1:0] != 2'b00);
            n_cmp++; if (ready !== exp_rdy) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b expected %b", k, ready, exp_rdy); end
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            @(posedge clock); #1;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        test_random();
`ifdef TBUS_RSP_BACKPRESSURE_EN
        test_backpressure();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
